// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one physical line-wide memory port between the
// instruction cache (read-only) and the data cache (read/write), with a watchdog.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              imem_read,
    input  logic [ADDR_W-1:0] imem_addr,
    output logic              imem_resp,
    output logic [LINE_W-1:0] imem_rdata,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_addr,
    input  logic [LINE_W-1:0] dmem_wdata,
    output logic              dmem_resp,
    output logic [LINE_W-1:0] dmem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_resp,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              err_timeout
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_I  = 2'd1;
    localparam logic [1:0] S_BUSY_D  = 2'd2;
    localparam logic [1:0] S_RECOVER = 2'd3;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic             last_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             ireq, dreq, grant_d, grant_i;

    // Tie goes to whoever was not served last.
    assign ireq    = imem_read;
    assign dreq    = dmem_read | dmem_write;
    assign grant_d = dreq & (~ireq | ~last_d);
    assign grant_i = ireq & ~grant_d;

    assign imem_resp  = (state == S_BUSY_I) & mem_resp;
    assign dmem_resp  = (state == S_BUSY_D) & mem_resp;
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            last_d      <= 1'b0;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_d) begin
                        mem_addr  <= dmem_addr;
                        mem_wdata <= dmem_wdata;
                        mem_write <= dmem_write;
                        mem_read  <= ~dmem_write;
                        last_d    <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= S_BUSY_D;
                    end else if (grant_i) begin
                        mem_addr  <= imem_addr;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        last_d    <= 1'b0;
                        wait_cnt  <= '0;
                        state     <= S_BUSY_I;
                    end
                end
                S_BUSY_I, S_BUSY_D: begin
                    if (mem_resp) begin
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        state     <= S_RECOVER;
                    end else if (wait_cnt == CNT_MAX) begin
                        // Keep holding: a slow memory may still answer.
                        err_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
